// File: rtl/button_event_decoder.sv
// Button gesture decoder: synchronizes a debounced button and classifies
// click sequences into short, long and double events plus raw edge pulses.
module button_event_decoder #(
  parameter int unsigned p_TICK_DIV     = 50000,
  parameter int unsigned p_LONG_TICKS   = 500,
  parameter int unsigned p_DOUBLE_TICKS = 250
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET_N,
  input  logic i_BTN,
  output logic o_HELD,
  output logic o_PRESS,
  output logic o_RELEASE,
  output logic o_SHORT,
  output logic o_LONG,
  output logic o_DOUBLE
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_PRESSED1    = 3'd1;
  localparam logic [2:0] ST_WAIT_SECOND = 3'd2;
  localparam logic [2:0] ST_PRESSED2    = 3'd3;
  localparam logic [2:0] ST_LONG_HELD   = 3'd4;

  localparam logic [15:0] DIV_LAST     = 16'(p_TICK_DIV - 1);
  localparam logic [9:0]  LONG_TICKS   = 10'(p_LONG_TICKS);
  localparam logic [9:0]  DOUBLE_TICKS = 10'(p_DOUBLE_TICKS);
  localparam logic [9:0]  TICK_MAX     = 10'd1023;

  logic [1:0]  sync_reg;
  logic        level_reg;
  logic        held_reg;
  logic        press_reg;
  logic        release_reg;
  logic        short_reg;
  logic        long_reg;
  logic        double_reg;
  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic [15:0] presc_reg;
  logic [15:0] presc_next;
  logic [9:0]  tick_cnt_reg;
  logic [9:0]  tick_cnt_next;
  logic [9:0]  tick_inc;
  logic        tick;
  logic        long_hit;
  logic        double_hit;
  logic        state_change;
  logic        press_edge;
  logic        release_edge;
  logic        short_next;
  logic        long_next;
  logic        double_next;

  // level_reg is the synchronized level; held_reg is its previous value and
  // doubles as the o_HELD output, so edges and o_HELD land on the same edge.
  always_ff @(posedge i_SYS_CLOCK) begin
    if (!i_RESET_N) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], i_BTN};
      level_reg <= sync_reg[1];
      held_reg  <= level_reg;
    end
  end

  assign press_edge   = level_reg & ~held_reg;
  assign release_edge = ~level_reg & held_reg;

  // Tick timer: thresholds compare against the value the counter is about to
  // take, so the event fires exactly N*p_TICK_DIV cycles after state entry.
  always_comb begin
    tick     = (presc_reg == DIV_LAST);
    tick_inc = (tick_cnt_reg == TICK_MAX) ? TICK_MAX : tick_cnt_reg + 10'd1;
    long_hit   = tick && (tick_inc == LONG_TICKS);
    double_hit = tick && (tick_inc == DOUBLE_TICKS);
  end

  always_comb begin
    state_next  = state_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (press_edge) state_next = ST_PRESSED1;
      end
      ST_PRESSED1: begin
        if (release_edge) begin
          state_next = ST_WAIT_SECOND;
        end else if (long_hit) begin
          state_next = ST_LONG_HELD;
          long_next  = 1'b1;
        end
      end
      ST_WAIT_SECOND: begin
        if (press_edge) begin
          state_next = ST_PRESSED2;
        end else if (double_hit) begin
          state_next = ST_IDLE;
          short_next = 1'b1;
        end
      end
      ST_PRESSED2: begin
        if (release_edge) begin
          state_next  = ST_IDLE;
          double_next = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (release_edge) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign state_change = (state_next != state_reg);

  always_comb begin
    presc_next    = presc_reg;
    tick_cnt_next = tick_cnt_reg;
    if (state_change) begin
      presc_next    = 16'd0;
      tick_cnt_next = 10'd0;
    end else if (tick) begin
      presc_next    = 16'd0;
      tick_cnt_next = tick_inc;
    end else begin
      presc_next    = presc_reg + 16'd1;
    end
  end

  always_ff @(posedge i_SYS_CLOCK) begin
    if (!i_RESET_N) begin
      state_reg    <= ST_IDLE;
      presc_reg    <= 16'd0;
      tick_cnt_reg <= 10'd0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      short_reg    <= 1'b0;
      long_reg     <= 1'b0;
      double_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      tick_cnt_reg <= tick_cnt_next;
      press_reg    <= press_edge;
      release_reg  <= release_edge;
      short_reg    <= short_next;
      long_reg     <= long_next;
      double_reg   <= double_next;
    end
  end

  assign o_HELD    = held_reg;
  assign o_PRESS   = press_reg;
  assign o_RELEASE = release_reg;
  assign o_SHORT   = short_reg;
  assign o_LONG    = long_reg;
  assign o_DOUBLE  = double_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: stimulus queues expected pulses
// by cycle, a negedge monitor pops and compares whenever any pulse appears.
module tb_button_event_decoder;

  localparam logic [4:0] M_PRESS  = 5'b00001;
  localparam logic [4:0] M_REL    = 5'b00010;
  localparam logic [4:0] M_SHORT  = 5'b00100;
  localparam logic [4:0] M_LONG   = 5'b01000;
  localparam logic [4:0] M_DOUBLE = 5'b10000;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } evt_t;

  logic clk;
  logic rst_n;
  logic btn;
  logic held, press, release_p, short_p, long_p, double_p;

  int   cyc;
  int   checks;
  int   errors;
  evt_t exp_q[$];

  button_event_decoder #(
    .p_TICK_DIV    (4),
    .p_LONG_TICKS  (5),
    .p_DOUBLE_TICKS(3)
  ) dut (
    .i_SYS_CLOCK(clk),
    .i_RESET_N  (rst_n),
    .i_BTN      (btn),
    .o_HELD     (held),
    .o_PRESS    (press),
    .o_RELEASE  (release_p),
    .o_SHORT    (short_p),
    .o_LONG     (long_p),
    .o_DOUBLE   (double_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Keep the queue sorted by cycle; pulses due on the same cycle merge.
  task automatic expect_evt(input int c, input logic [4:0] m);
    int   i;
    evt_t e;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc < c) i++;
    if (i < exp_q.size() && exp_q[i].cyc == c) begin
      e      = exp_q[i];
      e.mask = e.mask | m;
      exp_q[i] = e;
    end else begin
      e.cyc  = c;
      e.mask = m;
      exp_q.insert(i, e);
    end
  endtask

  // Monitor: flag overdue expectations, then match any observed pulse.
  always @(negedge clk) begin
    logic [4:0] obs;
    evt_t       e;
    obs = {double_p, long_p, short_p, release_p, press};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: cycle %0d got nothing, want mask %05b at cycle %0d", cyc, e.mask, e.cyc);
    end
    if (obs != 5'b0) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d got mask %05b, want no pulse", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs != e.mask) begin
          errors++;
          $display("FAIL event_mask: cycle %0d got mask %05b, want %05b", cyc, obs, e.mask);
        end
        if (e.mask & (M_PRESS | M_REL)) begin
          checks++;
          if (held !== ((e.mask & M_PRESS) != 0)) begin
            errors++;
            $display("FAIL held_level: cycle %0d got %0b, want %0b", cyc, held, (e.mask & M_PRESS) != 0);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_for(input int h);
    btn = 1'b1;
    expect_evt(cyc + 4, M_PRESS);
    idle(h);
  endtask

  task automatic release_for(input int h);
    btn = 1'b0;
    expect_evt(cyc + 4, M_REL);
    idle(h);
  endtask

  task automatic check_zero(input string name);
    logic [5:0] o;
    o = {held, press, release_p, short_p, long_p, double_p};
    checks++;
    if (o !== 6'b0) begin
      errors++;
      $display("FAIL %s: cycle %0d got outputs %06b, want 000000", name, cyc, o);
    end
  endtask

  initial begin
    int a;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = 1'b0;

    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_state");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // Single click: short 12 cycles after the release reaches the FSM.
    a = cyc;
    expect_evt(a + 24, M_SHORT);
    press_for(8);
    release_for(30);

    // Long hold: long 20 cycles after PRESSED1 entry, silent release.
    a = cyc;
    expect_evt(a + 24, M_LONG);
    press_for(30);
    release_for(10);

    // Double click: second release carries the double pulse.
    a = cyc;
    expect_evt(a + 22, M_DOUBLE);
    press_for(6);
    release_for(6);
    press_for(6);
    release_for(20);

    // Late second press: short for the first click, then a fresh click.
    a = cyc;
    expect_evt(a + 22, M_SHORT);
    expect_evt(a + 42, M_SHORT);
    press_for(6);
    release_for(14);
    press_for(6);
    release_for(25);

    // Release lands on the long-threshold cycle: release wins.
    a = cyc;
    expect_evt(a + 36, M_SHORT);
    press_for(20);
    release_for(20);

    // Press lands on the double-timeout cycle: press wins.
    a = cyc;
    expect_evt(a + 28, M_DOUBLE);
    press_for(6);
    release_for(12);
    press_for(6);
    release_for(15);

    // Reset in PRESSED1 with the button held: old press abandoned.
    press_for(10);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_zero("mid_reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a = cyc;
    expect_evt(a + 4, M_PRESS);
    expect_evt(a + 22, M_SHORT);
    idle(6);
    release_for(25);

    idle(40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending events, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
